// File: rtl/reg_file_pkg.sv
// Shared defaults and data/address types for the multi-port register file.
package reg_file_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM_READ   = 2;
  localparam int REG_NUM_WRITE  = 2;
  localparam int REG_ZERO_REG   = 1;

  typedef logic [REG_DATA_WIDTH-1:0] data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register pending-producer bits with same-cycle write-clear lookup.
module busy_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_READ   = REG_NUM_READ,
  parameter int NUM_WRITE  = REG_NUM_WRITE,
  parameter int ZERO_REG   = REG_ZERO_REG
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 set_ena,
  input  logic [ADDR_WIDTH-1:0]                set_addr,
  input  logic [NUM_WRITE-1:0]                 write_ena,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  read_addr,
  output logic [NUM_READ-1:0]                  read_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_next_s;
  logic [DEPTH-1:0] set_s;
  logic [DEPTH-1:0] clr_s;

  // Decode set/clear masks; a set beats a clear to the same register.
  always_comb begin
    set_s = {{(DEPTH-1){1'b0}}, set_ena} << set_addr;
    clr_s = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (write_ena[w]) begin
        clr_s[write_addr[w]] = 1'b1;
      end else begin
        clr_s = clr_s;
      end
    end
    busy_next_s = (busy_r & ~clr_s) | set_s;
    if (ZERO_REG != 0) begin
      busy_next_s[0] = 1'b0;
    end else begin
      busy_next_s[0] = busy_next_s[0];
    end
  end

  // Busy bit state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Lookup hides a bit whose producer is writing back this very cycle.
  always_comb begin
    read_busy = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      if (clr_s[read_addr[r]] && !set_s[read_addr[r]]) begin
        read_busy[r] = 1'b0;
      end else begin
        read_busy[r] = busy_r[read_addr[r]];
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: write-first bypass reads, collision flag and
// busy scoreboard for pending producers.
module register_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_READ   = REG_NUM_READ,
  parameter int NUM_WRITE  = REG_NUM_WRITE,
  parameter int ZERO_REG   = REG_ZERO_REG
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  read_Addr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  read_Data,
  output logic [NUM_READ-1:0]                  read_Busy,
  input  logic [NUM_WRITE-1:0]                 write_Ena,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] write_Addr,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] write_Data,
  input  logic                                 busy_Set_Ena,
  input  logic [ADDR_WIDTH-1:0]                busy_Set_Addr,
  output logic                                 write_Conflict
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [NUM_WRITE-1:0]  wr_valid_s;
  logic                  conflict_s;

  // A write is effective unless it targets the hard-wired zero register.
  always_comb begin
    wr_valid_s = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if ((ZERO_REG != 0) && (write_Addr[w] == '0)) begin
        wr_valid_s[w] = 1'b0;
      end else begin
        wr_valid_s[w] = write_Ena[w];
      end
    end
  end

  // Storage; ascending port order lets the highest-index port win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_valid_s[w]) begin
          mem_r[write_Addr[w]] <= write_Data[w];
        end
      end
    end
  end

  // Combinational read with write-first bypass, blanked during reset.
  always_comb begin
    read_Data = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      if (rst) begin
        read_Data[r] = mem_r[read_Addr[r]];
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_valid_s[w] && (write_Addr[w] == read_Addr[r])) begin
            read_Data[r] = write_Data[w];
          end else begin
            read_Data[r] = read_Data[r];
          end
        end
      end else begin
        read_Data[r] = '0;
      end
    end
  end

  // Detect two effective writes aimed at the same register.
  always_comb begin
    conflict_s = 1'b0;
    for (int a = 0; a < NUM_WRITE; a++) begin
      for (int b = a + 1; b < NUM_WRITE; b++) begin
        if (wr_valid_s[a] && wr_valid_s[b] && (write_Addr[a] == write_Addr[b])) begin
          conflict_s = 1'b1;
        end else begin
          conflict_s = conflict_s;
        end
      end
    end
  end

  // Conflict pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_Conflict <= 1'b0;
    end else begin
      write_Conflict <= conflict_s;
    end
  end

  busy_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_busy (
    .clk        (clk),
    .rst        (rst),
    .set_ena    (busy_Set_Ena),
    .set_addr   (busy_Set_Addr),
    .write_ena  (write_Ena),
    .write_addr (write_Addr),
    .read_addr  (read_Addr),
    .read_busy  (read_Busy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp at default parameters.
module tb_register_file_mp;
  import reg_file_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [1:0][4:0]      read_Addr;
  logic [1:0][31:0]     read_Data;
  logic [1:0]           read_Busy;
  logic [1:0]           write_Ena;
  logic [1:0][4:0]      write_Addr;
  logic [1:0][31:0]     write_Data;
  logic                 busy_Set_Ena;
  logic [4:0]           busy_Set_Addr;
  logic                 write_Conflict;

  int n_cmp;
  int n_fail;

  register_file_mp dut (
    .clk            (clk),
    .rst            (rst),
    .read_Addr      (read_Addr),
    .read_Data      (read_Data),
    .read_Busy      (read_Busy),
    .write_Ena      (write_Ena),
    .write_Addr     (write_Addr),
    .write_Data     (write_Data),
    .busy_Set_Ena   (busy_Set_Ena),
    .busy_Set_Addr  (busy_Set_Addr),
    .write_Conflict (write_Conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    write_Ena    = 2'b00;
    busy_Set_Ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    read_Addr  = {5'd3, 5'd0};
    write_Addr = '0;
    write_Data = '0;
    busy_Set_Addr = 5'd0;
    #3;
    n_cmp++;
    if (read_Data[1] !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected %h", read_Data[1], 32'h0);
    end
    n_cmp++;
    if (read_Busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy: got %b expected %b", read_Busy, 2'b00);
    end
    n_cmp++;
    if (write_Conflict !== 1'b0) begin
      n_fail++; $display("FAIL reset_conflict: got %b expected %b", write_Conflict, 1'b0);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_midrun();
    write_Ena = 2'b01; write_Addr[0] = 5'd3; write_Data[0] = 32'hFFFFFFFF;
    tick();
    idle();
    read_Addr[0] = 5'd3;
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL pre_reset_r3: got %h expected %h", read_Data[0], 32'hFFFFFFFF);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h00000000) begin
      n_fail++; $display("FAIL midrun_reset_r3: got %h expected %h", read_Data[0], 32'h0);
    end
    n_cmp++;
    if (write_Conflict !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_conflict: got %b expected %b", write_Conflict, 1'b0);
    end
    // A write and busy set presented under reset must be dropped.
    write_Ena = 2'b01; write_Data[0] = 32'h12345678;
    busy_Set_Ena = 1'b1; busy_Set_Addr = 5'd3;
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h00000000) begin
      n_fail++; $display("FAIL reset_discard_write: got %h expected %h", read_Data[0], 32'h0);
    end
    n_cmp++;
    if (read_Busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard_busy: got %b expected %b", read_Busy[0], 1'b0);
    end
    tick();
  endtask

  task automatic test_write_read();
    write_Ena = 2'b01; write_Addr[0] = 5'd1; write_Data[0] = 32'h88888888;
    tick();
    idle();
    read_Addr = {5'd1, 5'd1};
    #1;
    for (int p = 0; p < 2; p++) begin
      n_cmp++;
      if (read_Data[p] !== 32'h88888888) begin
        n_fail++; $display("FAIL write_read_p%0d: got %h expected %h", p, read_Data[p], 32'h88888888);
      end
    end
    // Two ports writing different registers together, no collision.
    write_Ena = 2'b11;
    write_Addr = {5'd9, 5'd6};
    write_Data = {32'h0000000B, 32'h0000000A};
    tick();
    idle();
    read_Addr = {5'd9, 5'd6};
    #1;
    n_cmp++;
    if (read_Data !== {32'h0000000B, 32'h0000000A}) begin
      n_fail++; $display("FAIL dual_write: got %h expected %h", read_Data, {32'h0000000B, 32'h0000000A});
    end
    n_cmp++;
    if (write_Conflict !== 1'b0) begin
      n_fail++; $display("FAIL dual_write_conflict: got %b expected %b", write_Conflict, 1'b0);
    end
  endtask

  task automatic test_bypass();
    read_Addr = {5'd1, 5'd3};
    write_Ena = 2'b01; write_Addr[0] = 5'd3; write_Data[0] = 32'h55555555;
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h55555555) begin
      n_fail++; $display("FAIL bypass_p0: got %h expected %h", read_Data[0], 32'h55555555);
    end
    n_cmp++;
    if (read_Data[1] !== 32'h88888888) begin
      n_fail++; $display("FAIL bypass_other_port: got %h expected %h", read_Data[1], 32'h88888888);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h55555555) begin
      n_fail++; $display("FAIL bypass_stored: got %h expected %h", read_Data[0], 32'h55555555);
    end
    // Bypass to r0 must still read zero.
    read_Addr[0] = 5'd0;
    write_Ena = 2'b01; write_Addr[0] = 5'd0; write_Data[0] = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_r0: got %h expected %h", read_Data[0], 32'h0);
    end
    tick();
    idle();
  endtask

  task automatic test_collision();
    write_Ena = 2'b11;
    write_Addr = {5'd5, 5'd5};
    write_Data = {32'h22222222, 32'h11111111};
    read_Addr = {5'd5, 5'd5};
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h22222222) begin
      n_fail++; $display("FAIL collision_bypass: got %h expected %h", read_Data[0], 32'h22222222);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Data[1] !== 32'h22222222) begin
      n_fail++; $display("FAIL collision_stored: got %h expected %h", read_Data[1], 32'h22222222);
    end
    n_cmp++;
    if (write_Conflict !== 1'b1) begin
      n_fail++; $display("FAIL collision_flag: got %b expected %b", write_Conflict, 1'b1);
    end
    tick();
    n_cmp++;
    if (write_Conflict !== 1'b0) begin
      n_fail++; $display("FAIL collision_pulse_end: got %b expected %b", write_Conflict, 1'b0);
    end
    write_Ena = 2'b11;
    write_Addr = {5'd0, 5'd0};
    read_Addr = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Data[0] !== 32'h0) begin
      n_fail++; $display("FAIL collision_r0_data: got %h expected %h", read_Data[0], 32'h0);
    end
    n_cmp++;
    if (write_Conflict !== 1'b0) begin
      n_fail++; $display("FAIL collision_r0_flag: got %b expected %b", write_Conflict, 1'b0);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    read_Addr = {5'd0, 5'd7};
    busy_Set_Ena = 1'b1; busy_Set_Addr = 5'd7;
    #1;
    n_cmp++;
    if (read_Busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_before_edge: got %b expected %b", read_Busy[0], 1'b0);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_set: got %b expected %b", read_Busy[0], 1'b1);
    end
    write_Ena = 2'b10; write_Addr[1] = 5'd7; write_Data[1] = 32'h77777777;
    #1;
    n_cmp++;
    if (read_Busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_clear_same_cycle: got %b expected %b", read_Busy[0], 1'b0);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_cleared: got %b expected %b", read_Busy[0], 1'b0);
    end
    busy_Set_Ena = 1'b1; busy_Set_Addr = 5'd7;
    tick();
    write_Ena = 2'b01; write_Addr[0] = 5'd7; write_Data[0] = 32'h70707070;
    #1;
    n_cmp++;
    if (read_Busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_set_and_write_now: got %b expected %b", read_Busy[0], 1'b1);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_set_wins: got %b expected %b", read_Busy[0], 1'b1);
    end
    busy_Set_Ena = 1'b1; busy_Set_Addr = 5'd0;
    tick();
    idle();
    #1;
    n_cmp++;
    if (read_Busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL busy_r0: got %b expected %b", read_Busy[1], 1'b0);
    end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_reset_midrun();
    test_write_read();
    test_bypass();
    test_collision();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 The module SHALL take parameter ADDR_WIDTH, default 5, meaning address width; depth is 2**ADDR_WIDTH.
REQ-003 The module SHALL take parameter NUM_READ, default 2, meaning count of combinational read ports (1..4).
REQ-004 The module SHALL take parameter NUM_WRITE, default 2, meaning count of synchronous write ports (1..2).
REQ-005 The module SHALL take parameter ZERO_REG, default 1, meaning register 0 reads 0 and ignores writes.
REQ-006 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-008 The module SHALL have port read_Addr, input, NUM_READ x ADDR_WIDTH, per-port read address.
REQ-009 The module SHALL have port read_Data, output, NUM_READ x DATA_WIDTH, per-port read data.
REQ-010 The module SHALL have port read_Busy, output, NUM_READ, per-port pending-producer flag.
REQ-011 The module SHALL have port write_Ena, input, NUM_WRITE, per-port write enable.
REQ-012 The module SHALL have port write_Addr, input, NUM_WRITE x ADDR_WIDTH, per-port write address.
REQ-013 The module SHALL have port write_Data, input, NUM_WRITE x DATA_WIDTH, per-port write data.
REQ-014 The module SHALL have port busy_Set_Ena, input, 1, mark a destination register pending.
REQ-015 The module SHALL have port busy_Set_Addr, input, ADDR_WIDTH, the register to mark pending.
REQ-016 The module SHALL have port write_Conflict, output, 1, registered one-cycle pulse flagging a same-address write collision.

Function
REQ-017 On each rising clk edge, every write port with write_Ena=1 SHALL store write_Data into write_Addr; when ZERO_REG=1, address 0 is never written.
REQ-018 When two enabled write ports target the same address, the highest-index port SHALL win.
REQ-019 read_Data SHALL be combinational, with write-first bypass: when an enabled write targets read_Addr in the same cycle, the winning write_Data SHALL appear on read_Data; otherwise stored contents.
REQ-020 When ZERO_REG=1, read_Data for address 0 SHALL be 0 regardless of writes or bypass.
REQ-021 The module SHALL keep one busy bit per register; on a rising edge, busy_Set_Ena=1 sets busy[busy_Set_Addr], and any enabled write clears busy[write_Addr].
REQ-022 When a set and a clear hit the same address in the same cycle, the set SHALL win (newer producer issued).
REQ-023 read_Busy[i] SHALL equal busy[read_Addr[i]], forced to 0 when an enabled write to that address occurs in the same cycle without a same-cycle set; register 0 is never busy when ZERO_REG=1.
REQ-024 write_Conflict SHALL be 1 for exactly the cycle after one in which two or more enabled write ports targeted the same address (excluding address 0 when ZERO_REG=1); otherwise 0.
REQ-025 Latency SHALL be: write visible via bypass in the same cycle and from storage from the next cycle; busy set visible on read_Busy from the next cycle.

Reset
REQ-026 While rst=0, all registers, all busy bits and write_Conflict SHALL be 0 asynchronously; read_Data SHALL read 0 and read_Busy 0.
REQ-027 Writes and busy sets presented while rst=0 SHALL be discarded; normal operation SHALL resume on the first rising edge after rst returns to 1.

Structure
REQ-028 The default parameters and the data/address typedefs SHALL live in shared package reg_file_pkg.
REQ-029 The busy-bit logic and its read lookup SHALL be a sub-module named busy_scoreboard; storage, bypass and conflict detection stay in register_file_mp.

Verification
REQ-030 Reset: rst=0 mid-run after writing 0xFFFFFFFF to r3 -> read_Data for r3 reads 0x00000000 immediately; write_Conflict=0.
REQ-031 Write/read: port0 writes 0x88888888 to r1; next cycle read r1 on both ports -> 0x88888888 on both.
REQ-032 Bypass: port0 writes 0x55555555 to r3 while read_Addr[0]=r3 in the same cycle -> read_Data[0]=0x55555555 before the edge.
REQ-033 Collision: port0 writes 0x11111111 and port1 writes 0x22222222 to r5 -> r5 reads 0x22222222; write_Conflict=1 for one cycle; the same collision on r0 -> r0 reads 0, no conflict.
REQ-034 Scoreboard: set busy r7 -> read_Busy=1 from the next cycle; a write to r7 clears it (read_Busy=0 the same cycle); set plus write on r7 together -> stays busy.
